stack_sequencer: RTL
====================

STACK_SEQUENCER -- requirements
Module: stack_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data/address width.
REQ-002 SHALL have parameter COUNTP, default 4, register-index width.
REQ-003 SHALL have parameter SPREG, default 4'd15, stack-pointer register index.
REQ-004 SHALL have port clk_i  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port req_valid  input  1  push/pop request present.
REQ-007 SHALL have port req_ready  output  1  engine can accept a request.
REQ-008 SHALL have port req_op  input  1  0 = push, 1 = pop.
REQ-009 SHALL have port req_reg  input  COUNTP  pop destination register.
REQ-010 SHALL have port push_data  input  WIDTH  value to push.
REQ-011 SHALL have port sp_data_i  input  WIDTH  current SP, from register-file SP read port.
REQ-012 SHALL have ports bus_cyc_o, bus_stb_o, bus_we_o  output  1 each  bus cycle, strobe, write.
REQ-013 SHALL have ports bus_adr_o  output  WIDTH, bus_dat_o  output  WIDTH, bus_sel_o  output  4  bus address, write data, byte selects.
REQ-014 SHALL have ports bus_dat_i  input  WIDTH, bus_ack_i  input  1, bus_err_i  input  1  bus read data, acknowledge, error.
REQ-015 SHALL have ports rf_write_addr  output  COUNTP, rf_write_data  output  WIDTH, rf_write_en  output  2  general register write port.
REQ-016 SHALL have ports rf_sp_data  output  WIDTH, rf_sp_en  output  2  SP write port.
REQ-017 SHALL have ports done_o, err_o  output  1 each  one-cycle completion / abort pulses.

Function
REQ-018 SHALL implement states IDLE, BUS, WB.
REQ-019 IDLE: req_ready=1; on req_valid SHALL capture req_op, req_reg, push_data and sp_data_i, then go to BUS next cycle.
REQ-020 Push address SHALL be sp_data_i-4; pop address SHALL be sp_data_i; SP arithmetic SHALL be modulo 2^WIDTH.
REQ-021 BUS: bus_cyc_o=bus_stb_o=1, bus_sel_o=4'hF, bus_we_o=1 for push, 0 for pop; bus_adr_o and bus_dat_o SHALL stay constant until ack or err.
REQ-022 On bus_ack_i in BUS, SHALL latch bus_dat_i (pop), drop cyc/stb on the next cycle, and go to WB.
REQ-023 On bus_err_i in BUS (err wins if both err and ack are asserted), SHALL pulse err_o for one cycle, perform no register writes, and return to IDLE.
REQ-024 WB, push: rf_sp_en=2'h3, rf_sp_data=sp-4, rf_write_en=0; done_o=1 for one cycle; next state IDLE.
REQ-025 WB, pop: rf_write_en=2'h3, rf_write_addr=req_reg, rf_write_data=loaded word, rf_sp_en=2'h3, rf_sp_data=sp+4, both in the same cycle; done_o=1.
REQ-026 A pop with req_reg==SPREG SHALL write the loaded word through rf_write only, with rf_sp_en=0 (loaded value wins).
REQ-027 Outside WB, rf_write_en and rf_sp_en SHALL be 0.
REQ-028 req_ready SHALL be 0 in BUS and WB; requests there SHALL be ignored, not queued.
REQ-029 Minimum latency: request accepted at edge T, bus strobe visible T..T+1, ack at T+1 gives WB in cycle T+2 and req_ready=1 at T+3.
REQ-030 bus_ack_i/bus_err_i arriving in IDLE or WB SHALL be ignored.

Reset
REQ-031 While rst_i=0 at a clock edge, the state SHALL become IDLE and all outputs SHALL be 0 except req_ready=1.
REQ-032 Reset asserted in BUS or WB SHALL drop cyc/stb at that edge with no register write, done_o or err_o.

Verification
REQ-033 Push: sp_data_i=0x1000, push_data=0xDEADBEEF, ack after 2 cycles -> bus write to 0x0FFC with data 0xDEADBEEF, then rf_sp_en=3, rf_sp_data=0x0FFC, done_o pulse.
REQ-034 Pop: sp=0x0FFC, req_reg=3, bus_dat_i=0x12345678 -> read at 0x0FFC, then rf_write_addr=3, data 0x12345678, rf_sp_data=0x1000, both enables=3 in one cycle.
REQ-035 Wrap: push with sp=0 -> bus_adr_o=0xFFFFFFFC, rf_sp_data=0xFFFFFFFC; pop with sp=0xFFFFFFFC -> rf_sp_data=0.
REQ-036 Pop to SPREG: req_reg=15, load 0xAAAA0000 -> rf_write_addr=15, rf_write_data=0xAAAA0000, rf_sp_en=0.
REQ-037 bus_err_i in BUS -> err_o pulse, no enables, req_ready=1 next cycle; a req_valid held through BUS is accepted only after return to IDLE.
REQ-038 rst_i=0 mid-BUS -> cyc/stb=0 at that edge, no writeback, IDLE with req_ready=1.

Source files
------------

// File: rtl/stack_sequencer.sv
// Stack push/pop engine: turns one push or pop request into a single bus
// cycle at the stack pointer, then writes back the new SP and, for pops,
// the loaded word into the register file.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | ready for a request; captures op/reg/data/SP on req_valid
// BUS    | bus cycle in flight; waits for ack (to WB) or err (to IDLE)
// WB     | one-cycle register-file writeback and done pulse
module stack_sequencer #(
    parameter int                WIDTH  = 32,
    parameter int                COUNTP = 4,
    parameter logic [COUNTP-1:0] SPREG  = 4'd15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_op,
    input  logic [COUNTP-1:0] req_reg,
    input  logic [WIDTH-1:0]  push_data,
    input  logic [WIDTH-1:0]  sp_data_i,
    output logic              bus_cyc_o,
    output logic              bus_stb_o,
    output logic              bus_we_o,
    output logic [WIDTH-1:0]  bus_adr_o,
    output logic [WIDTH-1:0]  bus_dat_o,
    output logic [3:0]        bus_sel_o,
    input  logic [WIDTH-1:0]  bus_dat_i,
    input  logic              bus_ack_i,
    input  logic              bus_err_i,
    output logic [COUNTP-1:0] rf_write_addr,
    output logic [WIDTH-1:0]  rf_write_data,
    output logic [1:0]        rf_write_en,
    output logic [WIDTH-1:0]  rf_sp_data,
    output logic [1:0]        rf_sp_en,
    output logic              done_o,
    output logic              err_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_WB   = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] FOUR = WIDTH'(4);

    state_t            state_q, state_d;
    logic              op_q, op_d;
    logic [COUNTP-1:0] reg_q, reg_d;
    logic [WIDTH-1:0]  wdata_q, wdata_d;
    logic [WIDTH-1:0]  sp_q, sp_d;
    logic [WIDTH-1:0]  rdata_q, rdata_d;
    logic              err_q, err_d;

    // State and captured-request registers, synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            op_q    <= 1'b0;
            reg_q   <= '0;
            wdata_q <= '0;
            sp_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            reg_q   <= reg_d;
            wdata_q <= wdata_d;
            sp_q    <= sp_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Next state: capture only in IDLE, so the bus address/data stay frozen
    // for the whole BUS phase; err has priority over ack.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        reg_d   = reg_q;
        wdata_d = wdata_q;
        sp_d    = sp_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    reg_d   = req_reg;
                    wdata_d = push_data;
                    sp_d    = sp_data_i;
                    state_d = S_BUS;
                end
            end
            S_BUS: begin
                if (bus_err_i) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (bus_ack_i) begin
                    if (op_q) begin
                        rdata_d = bus_dat_i;
                    end
                    state_d = S_WB;
                end
            end
            S_WB: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from state; everything not owned by the current
    // state is driven to zero.
    always_comb begin
        req_ready     = 1'b0;
        bus_cyc_o     = 1'b0;
        bus_stb_o     = 1'b0;
        bus_we_o      = 1'b0;
        bus_adr_o     = '0;
        bus_dat_o     = '0;
        bus_sel_o     = 4'h0;
        rf_write_addr = '0;
        rf_write_data = '0;
        rf_write_en   = 2'h0;
        rf_sp_data    = '0;
        rf_sp_en      = 2'h0;
        done_o        = 1'b0;
        err_o         = err_q;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
            end
            S_BUS: begin
                bus_cyc_o = 1'b1;
                bus_stb_o = 1'b1;
                bus_sel_o = 4'hF;
                bus_we_o  = ~op_q;
                bus_adr_o = op_q ? sp_q : (sp_q - FOUR);
                bus_dat_o = op_q ? '0 : wdata_q;
            end
            S_WB: begin
                done_o = 1'b1;
                if (op_q) begin
                    rf_write_en   = 2'h3;
                    rf_write_addr = reg_q;
                    rf_write_data = rdata_q;
                    // A pop into SP itself: the loaded word wins over SP+4.
                    if (reg_q != SPREG) begin
                        rf_sp_en   = 2'h3;
                        rf_sp_data = sp_q + FOUR;
                    end
                end else begin
                    rf_sp_en   = 2'h3;
                    rf_sp_data = sp_q - FOUR;
                end
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

endmodule
